sc_mem_initiator: RTL and testbench

//  Bus-master sequencer that drives the single-cycle CPU's data-memory/IO port
//  (addr, datain, we in; dataout back) from a queued command stream.
//  It lets a debug/boot agent preload DRAM, poke out_port registers, and read
//  in_port values without the CPU core.
//  It sits in front of the data memory, muxed with the CPU's load/store path
//  (the mux is outside this block).
//  The address map is unchanged: addr[7]=1 selects IO, addr[7]=0 selects DRAM.

---
 rtl/sc_mem_initiator.sv | 140 ++++++++++++++
 tb/tb_sc_mem_initiator.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sc_mem_initiator.sv
// Bus-master sequencer for the single-cycle CPU data-memory/IO port.
// Queued load/store commands run one at a time, and responses come back in command order.
module sc_mem_initiator #(
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned READ_LATENCY = 0
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_write,
    output logic        rsp_io,
    output logic        rsp_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_datain,
    output logic        mem_we,
    input  logic [31:0] mem_dataout,
    output logic        busy
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned CW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam logic [CW-1:0] WaitLast = CW'((READ_LATENCY > 0) ? READ_LATENCY - 1 : 0);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    state_e          state_q, state_d;
    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   wait_cnt_q, wait_cnt_d;
    logic            fifo_write_q [FIFO_DEPTH];
    logic [31:0]     fifo_addr_q  [FIFO_DEPTH];
    logic [31:0]     fifo_wdata_q [FIFO_DEPTH];
    logic [31:0]     rsp_rdata_q;
    logic            rsp_write_q, rsp_io_q, rsp_err_q;

    logic        empty, full, push, pop, load_rsp;
    logic        head_write, aligned;
    logic [31:0] head_addr, head_wdata;

    // The pointer MSB is the wrap bit that tells full from empty.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign push  = cmd_valid && !full;

    assign head_write = fifo_write_q[rd_ptr_q[AW-1:0]];
    assign head_addr  = fifo_addr_q[rd_ptr_q[AW-1:0]];
    assign head_wdata = fifo_wdata_q[rd_ptr_q[AW-1:0]];
    assign aligned    = (head_addr[1:0] == 2'b00);

    always_ff @(posedge clock) begin
        if (push) begin
            fifo_write_q[wr_ptr_q[AW-1:0]] <= cmd_write;
            fifo_addr_q[wr_ptr_q[AW-1:0]]  <= cmd_addr;
            fifo_wdata_q[wr_ptr_q[AW-1:0]] <= cmd_wdata;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q     <= StIdle;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            wait_cnt_q  <= '0;
            rsp_rdata_q <= '0;
            rsp_write_q <= 1'b0;
            rsp_io_q    <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            if (load_rsp) begin
                rsp_rdata_q <= (!head_write && aligned) ? mem_dataout : 32'h0;
                rsp_write_q <= head_write;
                rsp_io_q    <= head_addr[7];
                rsp_err_q   <= !aligned;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        pop        = 1'b0;
        load_rsp   = 1'b0;
        mem_addr   = 32'h0;
        mem_datain = 32'h0;
        mem_we     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!empty) state_d = StIssue;
            end
            StIssue: begin
                mem_addr   = head_addr;
                mem_datain = head_wdata;
                mem_we     = head_write && aligned;
                if (head_write || !aligned || READ_LATENCY == 0) begin
                    pop      = 1'b1;
                    load_rsp = 1'b1;
                    state_d  = StResp;
                end else begin
                    wait_cnt_d = '0;
                    state_d    = StWait;
                end
            end
            StWait: begin
                mem_addr   = head_addr;
                mem_datain = head_wdata;
                if (wait_cnt_q == WaitLast) begin
                    pop      = 1'b1;
                    load_rsp = 1'b1;
                    state_d  = StResp;
                end else begin
                    wait_cnt_d = wait_cnt_q + CW'(1);
                end
            end
            StResp: begin
                if (rsp_ready) state_d = empty ? StIdle : StIssue;
            end
            default: state_d = StIdle;
        endcase
    end

    assign cmd_ready = !full;
    assign rsp_valid = (state_q == StResp);
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_write = rsp_write_q;
    assign rsp_io    = rsp_io_q;
    assign rsp_err   = rsp_err_q;
    assign busy      = (state_q != StIdle) || !empty;

endmodule

// File: tb/tb_sc_mem_initiator.sv
// Bench for sc_mem_initiator: a READ_LATENCY=0 instance on a DRAM/IO model, plus a
// READ_LATENCY=2 instance on a two-stage pipelined read model.
module tb_sc_mem_initiator;

    logic clock = 1'b0;
    logic resetn;
    always #5 clock = ~clock;

    logic        cmd_valid, cmd_ready, cmd_write, rsp_valid, rsp_ready, rsp_write, rsp_io;
    logic        rsp_err, mem_we, busy;
    logic [31:0] cmd_addr, cmd_wdata, rsp_rdata, mem_addr, mem_datain, mem_dataout;

    logic        b_cmd_valid, b_cmd_ready, b_cmd_write, b_rsp_valid, b_rsp_ready, b_rsp_write;
    logic        b_rsp_io, b_rsp_err, b_mem_we, b_busy;
    logic [31:0] b_cmd_addr, b_cmd_wdata, b_rsp_rdata, b_mem_addr, b_mem_datain, b_mem_dataout;

    sc_mem_initiator #(.FIFO_DEPTH(4), .READ_LATENCY(0)) u_dut (
        .clock(clock), .resetn(resetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_write(rsp_write), .rsp_io(rsp_io), .rsp_err(rsp_err),
        .mem_addr(mem_addr), .mem_datain(mem_datain), .mem_we(mem_we),
        .mem_dataout(mem_dataout), .busy(busy)
    );

    sc_mem_initiator #(.FIFO_DEPTH(4), .READ_LATENCY(2)) u_dut_rl2 (
        .clock(clock), .resetn(resetn),
        .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready), .cmd_write(b_cmd_write),
        .cmd_addr(b_cmd_addr), .cmd_wdata(b_cmd_wdata),
        .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_rdata(b_rsp_rdata),
        .rsp_write(b_rsp_write), .rsp_io(b_rsp_io), .rsp_err(b_rsp_err),
        .mem_addr(b_mem_addr), .mem_datain(b_mem_datain), .mem_we(b_mem_we),
        .mem_dataout(b_mem_dataout), .busy(b_busy)
    );

    // DRAM/IO model: writes land in the low phase; 0xC0 reads in_port0, other IO reads out_port0.
    logic [31:0] dram [32] = '{default: 32'h0};
    logic [31:0] out_port0 = 32'h0;
    logic [31:0] in_port0 = 32'h0000_1234;
    int          we_cycles = 0;

    always_comb begin
        if (mem_addr[7]) mem_dataout = (mem_addr[7:0] == 8'hC0) ? in_port0 : out_port0;
        else             mem_dataout = dram[mem_addr[6:2]];
    end

    always @(negedge clock) begin
        if (mem_we) begin
            we_cycles <= we_cycles + 1;
            if (mem_addr[7]) out_port0 <= mem_datain;
            else             dram[mem_addr[6:2]] <= mem_datain;
        end
    end

    // Read data valid only once the address has been held for two edges.
    logic [31:0] b_d1 = 32'h0, b_d2 = 32'h0;
    always @(posedge clock) begin
        b_d1 <= b_mem_addr ^ 32'hA5A5_0000;
        b_d2 <= b_d1;
    end
    assign b_mem_dataout = b_d2;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_io;
        logic        exp_err;
        int          exp_we;
    } vec_t;

    vec_t vecs [10];

    task automatic run_vec(input vec_t v, input int idx);
        int n;
        int we0;
        we0       = we_cycles;
        cmd_valid = 1'b1;
        cmd_write = v.write;
        cmd_addr  = v.addr;
        cmd_wdata = v.wdata;
        n = 0;
        while (!cmd_ready && n < 20) begin tick(); n++; end
        tick();
        cmd_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 20) begin tick(); n++; end
        check($sformatf("v%0d rsp_valid", idx), 32'(rsp_valid), 32'd1);
        check($sformatf("v%0d rsp_rdata", idx), rsp_rdata, v.exp_rdata);
        check($sformatf("v%0d rsp_write", idx), 32'(rsp_write), 32'(v.write));
        check($sformatf("v%0d rsp_io", idx), 32'(rsp_io), 32'(v.exp_io));
        check($sformatf("v%0d rsp_err", idx), 32'(rsp_err), 32'(v.exp_err));
        check($sformatf("v%0d resp mem_addr", idx), mem_addr, 32'h0);
        check($sformatf("v%0d we cycles", idx), 32'(we_cycles - we0), 32'(v.exp_we));
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic rl2_load(input logic [31:0] addr, input int exp_first, input int exp_held,
                            input logic [31:0] exp_rdata, input logic exp_err, input string tag);
        int first;
        int held;
        b_cmd_valid = 1'b1;
        b_cmd_write = 1'b0;
        b_cmd_addr  = addr;
        tick();
        b_cmd_valid = 1'b0;
        tick();
        first = -1;
        held  = 0;
        for (int c = 0; c < 10; c++) begin
            if (b_rsp_valid) begin
                first = c;
                break;
            end
            if (b_mem_addr == addr && !b_mem_we) held++;
            tick();
        end
        check({tag, " rsp cycle"}, 32'(first), 32'(exp_first));
        check({tag, " addr held"}, 32'(held), 32'(exp_held));
        check({tag, " rsp_rdata"}, b_rsp_rdata, exp_rdata);
        check({tag, " rsp_err"}, 32'(b_rsp_err), 32'(exp_err));
        tick();
    endtask

    logic        t3_wr  [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [31:0] t3_ad  [5] = '{32'h30, 32'h34, 32'h30, 32'h34, 32'h10};
    logic [31:0] t3_wd  [5] = '{32'h1, 32'h2, 32'h0, 32'h0, 32'h0};
    logic [31:0] t3_exp [5] = '{32'h0, 32'h0, 32'h1, 32'h2, 32'hDEAD_BEEF};
    int          got;

    initial begin
        vecs[0] = '{1'b1, 32'h10, 32'hDEAD_BEEF, 32'h0,         1'b0, 1'b0, 1};
        vecs[1] = '{1'b0, 32'h10, 32'h0,         32'hDEAD_BEEF, 1'b0, 1'b0, 0};
        vecs[2] = '{1'b1, 32'h80, 32'h0000_00A5, 32'h0,         1'b1, 1'b0, 1};
        vecs[3] = '{1'b0, 32'hC0, 32'h0,         32'h0000_1234, 1'b1, 1'b0, 0};
        vecs[4] = '{1'b0, 32'h06, 32'h0,         32'h0,         1'b0, 1'b1, 0};
        vecs[5] = '{1'b1, 32'h20, 32'h1234_5678, 32'h0,         1'b0, 1'b0, 1};
        vecs[6] = '{1'b0, 32'h20, 32'h0,         32'h1234_5678, 1'b0, 1'b0, 0};
        vecs[7] = '{1'b1, 32'h23, 32'h0000_FFFF, 32'h0,         1'b0, 1'b1, 0};
        vecs[8] = '{1'b0, 32'h20, 32'h0,         32'h1234_5678, 1'b0, 1'b0, 0};
        vecs[9] = '{1'b0, 32'h84, 32'h0,         32'h0000_00A5, 1'b1, 1'b0, 0};

        resetn      = 1'b0;
        cmd_valid   = 1'b0; cmd_write   = 1'b0; cmd_addr   = '0; cmd_wdata   = '0;
        rsp_ready   = 1'b0;
        b_cmd_valid = 1'b0; b_cmd_write = 1'b0; b_cmd_addr = '0; b_cmd_wdata = '0;
        b_rsp_ready = 1'b1;
        tick();
        tick();
        check("reset cmd_ready", 32'(cmd_ready), 32'd1);
        check("reset rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset mem_we", 32'(mem_we), 32'd0);
        check("reset mem_addr", mem_addr, 32'h0);
        check("reset rsp_rdata", rsp_rdata, 32'h0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset rl2 cmd_ready", 32'(b_cmd_ready), 32'd1);
        resetn = 1'b1;
        tick();

        for (int i = 0; i < 10; i++) run_vec(vecs[i], i);
        check("out_port0", out_port0, 32'h0000_00A5);

        // Five back-to-back commands with responses stalled.
        rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cmd_valid = 1'b1;
            cmd_write = t3_wr[i];
            cmd_addr  = t3_ad[i];
            cmd_wdata = t3_wd[i];
            check($sformatf("burst cmd_ready %0d", i), 32'(cmd_ready), 32'd1);
            tick();
        end
        cmd_valid = 1'b0;
        check("burst full cmd_ready", 32'(cmd_ready), 32'd0);
        check("burst rsp_valid", 32'(rsp_valid), 32'd1);
        check("burst busy", 32'(busy), 32'd1);
        tick();
        tick();
        check("burst stalled cmd_ready", 32'(cmd_ready), 32'd0);
        rsp_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 40 && got < 5; c++) begin
            if (rsp_valid) begin
                check($sformatf("burst rdata %0d", got), rsp_rdata, t3_exp[got]);
                check($sformatf("burst write %0d", got), 32'(rsp_write), 32'(t3_wr[got]));
                got++;
            end
            tick();
        end
        rsp_ready = 1'b0;
        check("burst responses", 32'(got), 32'd5);
        check("burst busy after", 32'(busy), 32'd0);

        // Reset in the middle of a store's ISSUE cycle with three commands behind it.
        for (int i = 0; i < 5; i++) begin
            cmd_valid = 1'b1;
            cmd_write = 1'b1;
            cmd_addr  = 32'h40 + 32'(4 * i);
            cmd_wdata = 32'h100 + 32'(i);
            tick();
        end
        cmd_valid = 1'b0;
        check("rst pre rsp_valid", 32'(rsp_valid), 32'd1);
        rsp_ready = 1'b1;
        tick();
        check("rst issue mem_we", 32'(mem_we), 32'd1);
        check("rst issue mem_addr", mem_addr, 32'h44);
        #2;
        resetn = 1'b0;
        #1;
        check("rst mem_we", 32'(mem_we), 32'd0);
        check("rst rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst busy", 32'(busy), 32'd0);
        rsp_ready = 1'b0;
        tick();
        resetn = 1'b1;
        tick();
        tick();
        check("post rst rsp_valid", 32'(rsp_valid), 32'd0);
        check("post rst busy", 32'(busy), 32'd0);
        check("post rst cmd_ready", 32'(cmd_ready), 32'd1);
        check("post rst mem_we", 32'(mem_we), 32'd0);

        rl2_load(32'h14, 3, 3, 32'hA5A5_0014, 1'b0, "rl2 load");
        rl2_load(32'h16, 1, 1, 32'h0, 1'b1, "rl2 misaligned");
        check("rl2 busy after", 32'(b_busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
